shift_unit_mc: RTL
==================

// Module: shift_unit_mc
// PURPOSE
//  Parametrised multi-cycle shifter for the CPU execute stage: SLL/SRL/SRA (+ optional ROR).
//  Shifts up to STEP bit positions per clock under FSM control; operand/result use valid/ready.
//  Replaces the single-width combinational arithmetic-right shifter with a width-generic, area-scalable unit.
// PARAMETERS
//  WIDTH  16  data width; power of two, >= 4
//  STEP   4   max positions shifted per cycle; power of two, 1..WIDTH
//  SHW    $clog2(WIDTH)  shamt width (localparam, derived)
// PORTS
//  clk        in   1      clock, all state updates on rising edge
//  reset      in   1      synchronous, active-high reset
//  in_valid   in   1      operand request valid
//  in_ready   out  1      unit can accept (state==IDLE)
//  op         in   2      00 SLL, 01 SRL, 10 SRA, 11 ROR (ROR only with macro)
//  a          in   WIDTH  operand
//  shamt      in   SHW    shift amount 0..WIDTH-1
//  out_valid  out  1      result valid (state==DONE)
//  out_ready  in   1      consumer takes result
//  result     out  WIDTH  shifted value, held stable while out_valid
//  busy       out  1      state==BUSY
// BEHAVIOUR
//  - One clock; reset synchronous active-high. After reset edge: state IDLE, in_ready=1, out_valid=0, busy=0, result=0, rem=0.
//  - Reset mid-operation aborts: in-flight op discarded, no out_valid ever issued for it.
//  - FSM IDLE -> BUSY -> DONE -> IDLE. in_ready, busy, out_valid are decoded from state only.
//  - IDLE: in_valid&in_ready at edge k: latch a->acc, op, rem=shamt, fill=a[WIDTH-1]; go BUSY.
//  - BUSY each edge: s=min(rem,STEP); acc shifted by s per op; rem-=s; if new rem==0 -> DONE.
//    rem==0 on entry (shamt=0): no shift, -> DONE next edge.
//  - Latency: out_valid asserted after edge k+max(1,ceil(shamt/STEP)); STEP=4,shamt=9 -> 3 cycles.
//  - DONE: result=acc held; leaves only on out_valid&out_ready -> IDLE. No accept in DONE (one outstanding op).
//  - Inputs ignored outside IDLE; a/op/shamt changes during BUSY have no effect.
//  - SLL: zero fill LSBs. SRL: zero fill MSBs. SRA: MSBs filled with captured sign bit.
//  - Arithmetic in WIDTH bits; bits shifted out are discarded; shamt>=WIDTH unrepresentable by width.
//  - result register updated only when entering DONE; retains last value in IDLE.
// CONFIGURATION
//  - Macro SHIFT_UNIT_ROTATE_EN defined: op 11 = ROR, bits leaving LSB re-enter MSB, same latency rule.
//  - Not defined: op 11 decodes as SRL (identical result and latency); no rotate logic synthesised.
// STRUCTURE
//  - Package shift_pkg: op codes OP_SLL/OP_SRL/OP_SRA/OP_ROR (2-bit localparams), state enum
//    {ST_IDLE, ST_BUSY, ST_DONE}.
//  - Sub-module shift_step: combinational, parameters WIDTH/STEP; inputs acc, op, fill, s (0..STEP);
//    outputs next acc. shift_unit_mc holds FSM, rem counter, handshake, result register.
// TESTING
//  - Reset: assert reset 2 cycles mid-BUSY -> next cycle in_ready=1, out_valid=0, result=0, no stale result later.
//  - SRA: a=16'h8002, shamt=1, op=SRA -> result=16'hC001 after 1 cycle; a=16'h0002 -> 16'h0001.
//  - Multi-step: a=16'hFFFF, shamt=9, op=SRL, STEP=4 -> out_valid 3 cycles after accept, result=16'h007F.
//  - shamt=0, op=SLL, a=16'h1234 -> result 16'h1234 after 1 cycle; SLL a=16'h0001 shamt=15 -> 16'h8000.
//  - Backpressure: hold out_ready=0 10 cycles -> result, out_valid stable, in_ready=0, new in_valid ignored.
//  - Rotate (macro on): a=16'h0001, shamt=1, op=11 -> 16'h8000; macro off same stimulus -> 16'h0000.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared op codes and FSM state type for the multi-cycle shifter.
package shift_pkg;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/shift_step.sv
// One shift step of up to STEP positions; combinational.
// Rotate datapath only present when SHIFT_UNIT_ROTATE_EN is defined.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 4
) (
  input  logic [WIDTH-1:0]         acc_i,
  input  logic [1:0]               op_i,
  input  logic                     fill_i,
  input  logic [$clog2(WIDTH):0]   s_i,
  output logic [WIDTH-1:0]         acc_o
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] STEP_W  = (SHW+1)'(STEP);
  localparam logic [SHW:0] WIDTH_W = (SHW+1)'(WIDTH);
  localparam logic [WIDTH-1:0] ONES = '1;

  logic [SHW:0] s_eff;

  always_comb begin
    s_eff = (s_i > STEP_W) ? STEP_W : s_i;
    acc_o = acc_i;
    case (op_i)
      OP_SLL: acc_o = acc_i << s_eff;
      OP_SRL: acc_o = acc_i >> s_eff;
      // Vacated MSBs take the sign captured at accept time.
      OP_SRA: acc_o = (acc_i >> s_eff) | (fill_i ? ~(ONES >> s_eff) : '0);
`ifdef SHIFT_UNIT_ROTATE_EN
      OP_ROR: acc_o = (acc_i >> s_eff) | (acc_i << (WIDTH_W - s_eff));
`else
      OP_ROR: acc_o = acc_i >> s_eff;
`endif
      default: acc_o = acc_i;
    endcase
  end

endmodule

// File: rtl/shift_unit_mc.sv
// Multi-cycle SLL/SRL/SRA shifter with valid/ready handshake on both sides.
// Define SHIFT_UNIT_ROTATE_EN to make op 11 a rotate-right instead of SRL.
module shift_unit_mc
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               op,
  input  logic [WIDTH-1:0]         a,
  input  logic [$clog2(WIDTH)-1:0] shamt,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         result,
  output logic                     busy
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] STEP_W = (SHW+1)'(STEP);

  state_e           state_q;
  logic [WIDTH-1:0] acc_q, acc_d, result_q;
  logic [1:0]       op_q;
  logic             fill_q;
  logic [SHW-1:0]   rem_q, rem_d;
  logic [SHW:0]     s_w;

  // s never exceeds rem, so it always fits back into SHW bits
  always_comb begin
    s_w   = ({1'b0, rem_q} < STEP_W) ? {1'b0, rem_q} : STEP_W;
    rem_d = rem_q - SHW'(s_w);
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .acc_i  (acc_q),
    .op_i   (op_q),
    .fill_i (fill_q),
    .s_i    (s_w),
    .acc_o  (acc_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      op_q     <= OP_SLL;
      fill_q   <= 1'b0;
      rem_q    <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            acc_q   <= a;
            op_q    <= op;
            rem_q   <= shamt;
            fill_q  <= a[WIDTH-1];
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          acc_q <= acc_d;
          rem_q <= rem_d;
          if (rem_d == '0) begin
            result_q <= acc_d;
            state_q  <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_BUSY);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;

endmodule
